sfu_acc_fifo: RTL and testbench
===============================

# sfu_acc_fifo

Parametrised successor to the single-window accumulate/ReLU special function unit. It sits after the systolic array's output path and accumulates a programmable number of `psum` beats per column. It applies a per-window selectable activation with signed saturation, and queues finished results in an output FIFO with a valid/ready handshake, so the array keeps streaming while downstream stalls.

## Interface
- `psum_bw`, 16: per-column input/output width, signed two's complement.
- `acc_bw`, 20: per-column internal accumulator width; must be ≥ `psum_bw`.
- `col`, 8: number of columns (independent lanes).
- `cnt_bw`, 8: width of the accumulation-length field.
- `depth`, 4: output FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that opens a window; honoured only in IDLE.
- `acc_len`  in  `cnt_bw`  beats per window, sampled with `start`; 0 is treated as 1.
- `mode`  in  2  activation, sampled with `start`: 00 pass, 01 ReLU, 10 abs, 11 same as pass.
- `in_valid`  in  1  `psum_in` beat present.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `psum_in`  in  `col*psum_bw`  lane k at bits `[(k+1)*psum_bw-1 : k*psum_bw]`.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  pop when `out_valid && out_ready`.
- `psum_out`  out  `col*psum_bw`  FIFO head entry, same lane packing.
- `busy`  out  1  high in ACC state.
- `sat_o`  out  1  sticky: some lane saturated in the current or last window; cleared by an accepted `start`.

## Operation
- FSM has two states.
  - IDLE: `in_ready`=0. `start`=1 latches `acc_len` and `mode`, clears the accumulators, beat counter and `sat_o`, and moves to ACC.
  - ACC: `busy`=1. Each accepted beat adds the sign-extended `psum_in` lane to `acc` lane, wrapping in `acc_bw` bits, and increments the counter.
- Last beat (counter == len-1):
  - The result is computed from `acc + psum_in` of that beat.
  - The result is pushed to the FIFO on the same edge, and the FSM returns to IDLE.
- Result per lane:
  - Clamp the `acc_bw` signed sum to [−2^(psum_bw−1), 2^(psum_bw−1)−1]. Any lane clamped sets `sat_o`.
  - Then apply `mode`:
    - ReLU: negative → 0.
    - abs: negative x → −x; the clamped minimum maps to 2^(psum_bw−1)−1.
    - pass: unchanged.
- `in_ready` in ACC is 1, except on the last beat while the FIFO is full (registered count == `depth`). A same-cycle pop does not release it.
- `start` in ACC is ignored. `in_valid` in IDLE is ignored, and no beat is consumed.
- FIFO:
  - Circular with read and write pointers plus an occupancy count.
  - Push and pop in the same cycle leave the count unchanged.
  - `psum_out` shows the head entry. It holds stable while `out_valid && !out_ready`.
- Reset mid-window discards the partial sum and all FIFO contents.

## Timing
- Reset values:
  - Outputs: `in_ready`=0, `out_valid`=0, `psum_out`=0, `busy`=0, `sat_o`=0.
  - Internal: state IDLE, counter 0, FIFO empty, storage 0.
- `start` at edge N: `busy` and `in_ready` are high after N, so the first beat can be accepted at edge N+1.
- Last beat accepted at edge M, FIFO previously empty: `out_valid`=1 and `psum_out` valid after M (1-cycle latency). `busy`=0 after M.
- Throughput: one beat per cycle. A back-to-back window needs one IDLE cycle for `start`, so the minimum window period is len+1 cycles.
- A pop at edge P exposes the next entry after P. `out_valid` falls after P if that pop emptied the FIFO.
- FIFO full on the last beat: `in_ready` stays low until the cycle after a pop drops the count below `depth`. That beat is then accepted and pushed.

## Test plan
- Reset mid-window:
  - Stimulus: reset asserted with 2 FIFO entries queued and a window in progress.
  - Required: all outputs return to their reset values immediately (asynchronous). After release, `start` with len=1 and input 5 yields `psum_out` lane 5 and no stale entries.
- Basic ReLU window:
  - Stimulus: `start`, len=3, mode=01; lane0 inputs 10, −4, 7; lane1 inputs −20, 3, 1.
  - Required: one cycle after the third beat, `out_valid`=1 with lane0=13 and lane1=0, `sat_o`=0.
- Saturation in pass mode:
  - Stimulus: psum_bw=16, len=4, mode=00, all lanes 30000 per beat.
  - Required: output 32767 on every lane, `sat_o`=1. The next `start` clears `sat_o`.
- abs and negative clamp:
  - Stimulus: mode=10; lane0 beats −32768, −32768.
  - Required: lane0 output 32767, `sat_o`=1.
  - Stimulus: mode=10; lane1 sum −9.
  - Required: lane1 output 9.
- Backpressure and FIFO full:
  - Stimulus: depth=4, `out_ready`=0, five windows of len=1 with values 1..5.
  - Required: entries 1..4 queue. On the fifth window `in_ready`=0 and `busy`=1. Raising `out_ready` pops 1, 5 is then accepted, and outputs arrive in order 1,2,3,4,5.
- Protocol edges:
  - Stimulus: `in_valid` high in IDLE.
  - Required: no beat consumed and no push.
  - Stimulus: `start` during ACC.
  - Required: ignored, `acc_len` unchanged.
  - Stimulus: `acc_len`=0.
  - Required: window completes after exactly 1 beat.

Source files
------------

// File: rtl/sfu_acc_fifo.sv
// sfu_acc_fifo: multi-column accumulate / activation unit with an output FIFO.
//
// A window is opened by `start` in IDLE. acc_len and mode are latched, and the
// accumulators, beat counter and sticky saturation flag are cleared. In ACC,
// each accepted beat adds psum_in into every lane. The last beat computes
// clamp + activation from acc + psum_in and pushes the result into a circular
// FIFO on that same edge.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   start/acc_len/mode    window open pulse, beat count (0 == 1) and activation
//   in_valid/in_ready     psum_in beat handshake
//   psum_in               col lanes of psum_bw, lane k at [(k+1)*psum_bw-1 : k*psum_bw]
//   out_valid/out_ready   FIFO head handshake
//   psum_out              FIFO head entry, same lane packing
//   busy                  high in ACC
//   sat_o                 sticky: a lane was clamped in the current/last window

// Per-lane arithmetic: wrap-around accumulate, signed clamp, activation.
module sfu_acc_lane #(
    parameter int psum_bw = 16,
    parameter int acc_bw  = 20
) (
    input  logic [acc_bw-1:0]  acc,
    input  logic [psum_bw-1:0] psum,
    input  logic [1:0]         mode,
    output logic [acc_bw-1:0]  sum,
    output logic [psum_bw-1:0] res,
    output logic               sat
);
    localparam logic signed [acc_bw-1:0] MAXV = {{(acc_bw-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
    localparam logic signed [acc_bw-1:0] MINV = {{(acc_bw-psum_bw+1){1'b1}}, {(psum_bw-1){1'b0}}};
    localparam logic [psum_bw-1:0] MAXP = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] MINP = {1'b1, {(psum_bw-1){1'b0}}};

    logic signed [acc_bw-1:0] pext, s;
    logic                     hi, lo;
    logic [psum_bw-1:0]       clamped;

    always_comb begin
        pext = acc_bw'($signed(psum));
        s    = $signed(acc) + pext;
        sum  = s;
        hi   = s > MAXV;
        lo   = s < MINV;
        sat  = hi | lo;
        if (hi)      clamped = MAXP;
        else if (lo) clamped = MINP;
        else         clamped = s[psum_bw-1:0];
        case (mode)
            2'b01:   res = clamped[psum_bw-1] ? '0 : clamped;
            // abs of the clamped minimum has no positive twin; pin it to max
            2'b10:   res = !clamped[psum_bw-1] ? clamped :
                           (clamped == MINP) ? MAXP : -clamped;
            default: res = clamped;
        endcase
    end
endmodule

module sfu_acc_fifo #(
    parameter int psum_bw = 16,
    parameter int acc_bw  = 20,
    parameter int col     = 8,
    parameter int cnt_bw  = 8,
    parameter int depth   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [cnt_bw-1:0]      acc_len,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [col*psum_bw-1:0] psum_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [col*psum_bw-1:0] psum_out,
    output logic                   busy,
    output logic                   sat_o
);
    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ACC} state_t;
    state_t state_q, state_d;

    logic [cnt_bw-1:0]                  len_q, cnt_q;
    logic [1:0]                         mode_q;
    logic                               sat_q;
    logic [col-1:0][acc_bw-1:0]         acc_q, lane_sum;
    logic [col-1:0][psum_bw-1:0]        lane_in, lane_res;
    logic [col-1:0]                     lane_sat;
    logic [depth-1:0][col-1:0][psum_bw-1:0] mem;
    logic [PW-1:0]                      wr_ptr, rd_ptr;
    logic [CW-1:0]                      count;
    logic                               last, full, fire, push, pop;

    assign lane_in = psum_in;

    for (genvar k = 0; k < col; k++) begin : g_lane
        sfu_acc_lane #(.psum_bw(psum_bw), .acc_bw(acc_bw)) u_lane (
            .acc  (acc_q[k]),
            .psum (lane_in[k]),
            .mode (mode_q),
            .sum  (lane_sum[k]),
            .res  (lane_res[k]),
            .sat  (lane_sat[k])
        );
    end

    assign busy      = (state_q == ACC);
    assign full      = (count == CW'(depth));
    assign last      = busy && (cnt_q == len_q - cnt_bw'(1));
    // Only the last beat needs FIFO room; uses the registered count, so a
    // same-cycle pop does not let the beat in.
    assign in_ready  = busy && !(last && full);
    assign fire      = in_valid && in_ready;
    assign push      = fire && last;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign psum_out  = mem[rd_ptr];
    assign sat_o     = sat_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACC;
            ACC:     if (push)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q  <= '0;
            cnt_q  <= '0;
            mode_q <= '0;
            sat_q  <= 1'b0;
            acc_q  <= '0;
        end else if (state_q == IDLE && start) begin
            len_q  <= (acc_len == '0) ? cnt_bw'(1) : acc_len;
            mode_q <= mode;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
            acc_q  <= '0;
        end else if (fire) begin
            if (last) begin
                sat_q <= sat_q | (|lane_sat);
            end else begin
                acc_q <= lane_sum;
                cnt_q <= cnt_q + cnt_bw'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= lane_res;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_sfu_acc_fifo.sv
module tb_sfu_acc_fifo;
    localparam int COL = 8, PBW = 16, W = COL * PBW;

    logic         clk = 1'b0, reset = 1'b0;
    logic         start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]   acc_len = '0;
    logic [1:0]   mode = '0;
    logic [W-1:0] psum_in = '0;
    logic         in_ready, out_valid, busy, sat_o;
    logic [W-1:0] psum_out;

    int checks = 0, failures = 0;
    logic [W-1:0] beatq[$];

    always #5 clk = ~clk;

    sfu_acc_fifo #(.psum_bw(16), .acc_bw(20), .col(8), .cnt_bw(8), .depth(4)) dut (
        .clk(clk), .reset(reset), .start(start), .acc_len(acc_len), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .psum_in(psum_in),
        .out_valid(out_valid), .out_ready(out_ready), .psum_out(psum_out),
        .busy(busy), .sat_o(sat_o)
    );

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] splat(input logic [15:0] v);
        logic [W-1:0] r;
        for (int k = 0; k < COL; k++) r[k*PBW +: PBW] = v;
        return r;
    endfunction

    // Reference: integer sum of the window's beats, wrapped to 20 bits,
    // clamped to 16-bit signed, then activation.
    function automatic void model(input logic [1:0] m, output logic [W-1:0] res, output bit sat);
        sat = 1'b0;
        res = '0;
        for (int k = 0; k < COL; k++) begin
            int s = 0;
            int r;
            foreach (beatq[i]) begin
                logic signed [15:0] t;
                t = beatq[i][k*PBW +: PBW];
                s += int'(t);
            end
            s = s & 32'h000F_FFFF;
            if (s >= 524288) s -= 1048576;
            r = s;
            if (r > 32767)  begin r = 32767;  sat = 1'b1; end
            if (r < -32768) begin r = -32768; sat = 1'b1; end
            if (m == 2'b01 && r < 0) r = 0;
            if (m == 2'b10 && r < 0) r = (r == -32768) ? 32767 : -r;
            res[k*PBW +: PBW] = 16'(r);
        end
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 200) begin step(); t++; end
        if (t >= 200) begin
            checks++; failures++;
            $display("FAIL in_ready_timeout in_ready=%0b required=1", in_ready);
        end
    endtask

    task automatic run_window(input logic [7:0] len, input logic [1:0] m);
        start = 1'b1; acc_len = len; mode = m;
        step();
        start = 1'b0;
        foreach (beatq[i]) begin
            in_valid = 1'b1; psum_in = beatq[i];
            wait_ready();
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || psum_out !== '0 || busy !== 1'b0 || sat_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got rdy=%b ov=%b out=%h busy=%b sat=%b required all 0",
                     in_ready, out_valid, psum_out, busy, sat_o);
        end
        reset = 1'b1;
        step();
        beatq = '{splat(16'd11)}; run_window(8'd1, 2'b00);
        beatq = '{splat(16'd22)}; run_window(8'd1, 2'b00);
        start = 1'b1; acc_len = 8'd3; mode = 2'b00;
        step();
        start = 1'b0; in_valid = 1'b1; psum_in = splat(16'd1);
        step();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || psum_out !== '0 || busy !== 1'b0 || sat_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_midwindow got rdy=%b ov=%b out=%h busy=%b sat=%b required all 0",
                     in_ready, out_valid, psum_out, busy, sat_o);
        end
        #2 reset = 1'b1;
        step();
        beatq = '{splat(16'd5)}; run_window(8'd1, 2'b00);
        checks++;
        if (out_valid !== 1'b1 || psum_out !== splat(16'd5)) begin
            failures++;
            $display("FAIL reset_after_window got ov=%b out=%h required ov=1 out=%h", out_valid, psum_out, splat(16'd5));
        end
        pop_one();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_stale got ov=%b required 0", out_valid);
        end
    endtask

    task automatic test_relu();
        logic [W-1:0] b0, b1, b2, exp_v;
        bit exp_s;
        b0 = '0; b1 = '0; b2 = '0;
        for (int k = 2; k < COL; k++) begin
            b0[k*PBW +: PBW] = 16'($urandom_range(0, 200) - 100);
            b1[k*PBW +: PBW] = 16'($urandom_range(0, 200) - 100);
            b2[k*PBW +: PBW] = 16'($urandom_range(0, 200) - 100);
        end
        b0[15:0] = 16'd10; b1[15:0] = -16'sd4; b2[15:0] = 16'd7;
        b0[31:16] = -16'sd20; b1[31:16] = 16'd3; b2[31:16] = 16'd1;
        beatq = '{b0, b1, b2};
        model(2'b01, exp_v, exp_s);
        run_window(8'd3, 2'b01);
        checks++;
        if (out_valid !== 1'b1 || psum_out[15:0] !== 16'd13 || psum_out[31:16] !== 16'd0 || sat_o !== 1'b0) begin
            failures++;
            $display("FAIL relu_lanes got ov=%b l0=%0d l1=%0d sat=%b required ov=1 l0=13 l1=0 sat=0",
                     out_valid, psum_out[15:0], psum_out[31:16], sat_o);
        end
        checks++;
        if (psum_out !== exp_v || busy !== 1'b0) begin
            failures++;
            $display("FAIL relu_all got out=%h busy=%b required out=%h busy=0", psum_out, busy, exp_v);
        end
        pop_one();
    endtask

    task automatic test_sat();
        beatq = '{splat(16'd30000), splat(16'd30000), splat(16'd30000), splat(16'd30000)};
        run_window(8'd4, 2'b00);
        checks++;
        if (psum_out !== splat(16'd32767) || sat_o !== 1'b1) begin
            failures++;
            $display("FAIL sat_pass got out=%h sat=%b required out=%h sat=1", psum_out, sat_o, splat(16'd32767));
        end
        start = 1'b1; acc_len = 8'd1; mode = 2'b00;
        step();
        start = 1'b0;
        checks++;
        if (sat_o !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL sat_clear got sat=%b busy=%b required sat=0 busy=1", sat_o, busy);
        end
        in_valid = 1'b1; psum_in = '0;
        step();
        in_valid = 1'b0;
        pop_one();
        pop_one();
    endtask

    task automatic test_abs();
        logic [W-1:0] b0, b1, exp_v;
        bit exp_s;
        b0 = '0; b1 = '0;
        b0[15:0] = 16'h8000; b1[15:0] = 16'h8000;
        b0[31:16] = -16'sd4; b1[31:16] = -16'sd5;
        beatq = '{b0, b1};
        model(2'b10, exp_v, exp_s);
        run_window(8'd2, 2'b10);
        checks++;
        if (psum_out[15:0] !== 16'd32767 || psum_out[31:16] !== 16'd9 || sat_o !== 1'b1) begin
            failures++;
            $display("FAIL abs_lanes got l0=%0d l1=%0d sat=%b required l0=32767 l1=9 sat=1",
                     psum_out[15:0], psum_out[31:16], sat_o);
        end
        checks++;
        if (psum_out !== exp_v) begin
            failures++;
            $display("FAIL abs_all got out=%h required %h", psum_out, exp_v);
        end
        pop_one();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            beatq = '{splat(16'(v))};
            run_window(8'd1, 2'b00);
        end
        start = 1'b1; acc_len = 8'd1; mode = 2'b00;
        step();
        start = 1'b0; in_valid = 1'b1; psum_in = splat(16'd5);
        step(); step();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || psum_out !== splat(16'd1)) begin
            failures++;
            $display("FAIL bp_full got rdy=%b busy=%b head=%h required rdy=0 busy=1 head=%h",
                     in_ready, busy, psum_out, splat(16'd1));
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_samecycle_pop got rdy=%b required 0", in_ready);
        end
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || psum_out !== splat(16'd2)) begin
            failures++;
            $display("FAIL bp_release got rdy=%b head=%h required rdy=1 head=%h", in_ready, psum_out, splat(16'd2));
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept got busy=%b required 0", busy);
        end
        for (int v = 2; v <= 5; v++) begin
            checks++;
            if (out_valid !== 1'b1 || psum_out !== splat(16'(v))) begin
                failures++;
                $display("FAIL bp_order got ov=%b out=%h required ov=1 out=%h", out_valid, psum_out, splat(16'(v)));
            end
            pop_one();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got ov=%b required 0", out_valid);
        end
    endtask

    task automatic test_protocol();
        in_valid = 1'b1; psum_in = splat(16'd9);
        step(); step(); step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_valid got rdy=%b ov=%b busy=%b required 0 0 0", in_ready, out_valid, busy);
        end
        in_valid = 1'b0;
        start = 1'b1; acc_len = 8'd2; mode = 2'b00;
        step();
        in_valid = 1'b1; psum_in = splat(16'd3); acc_len = 8'd5;
        step();
        start = 1'b0; psum_in = splat(16'd4);
        step();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b1 || psum_out !== splat(16'd7)) begin
            failures++;
            $display("FAIL start_in_acc got busy=%b ov=%b out=%h required busy=0 ov=1 out=%h",
                     busy, out_valid, psum_out, splat(16'd7));
        end
        pop_one();
        start = 1'b1; acc_len = 8'd0;
        step();
        start = 1'b0; in_valid = 1'b1; psum_in = splat(-16'sd6);
        step();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b1 || psum_out !== splat(-16'sd6)) begin
            failures++;
            $display("FAIL len_zero got busy=%b ov=%b out=%h required busy=0 ov=1 out=%h",
                     busy, out_valid, psum_out, splat(-16'sd6));
        end
        pop_one();
    endtask

    task automatic test_random();
        logic [W-1:0] b, exp_v;
        bit exp_s;
        int len;
        logic [1:0] m;
        logic [7:0] lf;
        for (int n = 0; n < 30; n++) begin
            len = $urandom_range(1, 5);
            m = 2'($urandom_range(0, 3));
            beatq.delete();
            for (int i = 0; i < len; i++) begin
                for (int k = 0; k < COL; k++)
                    b[k*PBW +: PBW] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4000) - 2000);
                beatq.push_back(b);
            end
            lf = (len == 1 && $urandom_range(0, 1) == 1) ? 8'd0 : 8'(len);
            model(m, exp_v, exp_s);
            run_window(lf, m);
            checks++;
            if (out_valid !== 1'b1 || psum_out !== exp_v || sat_o !== exp_s) begin
                failures++;
                $display("FAIL random_window n=%0d mode=%0d got ov=%b out=%h sat=%b required ov=1 out=%h sat=%b",
                         n, m, out_valid, psum_out, sat_o, exp_v, exp_s);
            end
            pop_one();
        end
    endtask

    initial begin
        test_reset();
        test_relu();
        test_sat();
        test_abs();
        test_backpressure();
        test_protocol();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
